// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shift types,
// forwarding selects and the iterative-multiplier state machine.
// Pure declarations; no latency or backpressure of its own.
package arm_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Code 11 falls back to the register value.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
        case (sel)
            FWD_MEM: fwd_mux = mem_val;
            FWD_WB:  fwd_mux = wb_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

endpackage

// File: rtl/exe_val2_gen.sv
// Operand-2 generator: load/store offset, rotated immediate or shifted register.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module exe_val2_gen
    import arm_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    output logic [31:0] val2
);

    logic [31:0] imm_base;
    logic [63:0] imm_dbl;
    logic [63:0] rm_dbl;
    logic [4:0]  imm_rot;
    logic [4:0]  sh_amt;
    logic [1:0]  sh_type;
    logic [31:0] shifted;

    assign imm_base = {24'b0, shift_operand[7:0]};
    assign imm_rot  = {shift_operand[11:8], 1'b0};
    assign imm_dbl  = {imm_base, imm_base} >> imm_rot;
    assign sh_amt   = shift_operand[11:7];
    assign sh_type  = shift_operand[6:5];
    assign rm_dbl   = {val_rm, val_rm} >> sh_amt;

    always_comb begin
        shifted = val_rm;
        case (sh_type)
            SH_LSL:  shifted = val_rm << sh_amt;
            SH_LSR:  shifted = val_rm >> sh_amt;
            SH_ASR:  shifted = $unsigned($signed(val_rm) >>> sh_amt);
            default: shifted = rm_dbl[31:0];
        endcase
    end

    always_comb begin
        if (mem_en)
            val2 = {20'b0, shift_operand};
        else if (imm)
            val2 = imm_dbl[31:0];
        else
            val2 = shifted;
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: operand-2 generation, ALU/NZCV, branch target, iterative MUL.
// Latency: combinational result; MUL takes 32/MUL_BITS_PER_CYCLE+2 cycles (stall held meanwhile).
// Backpressure: stall holds upstream stages and forces bubbles downstream. Optional EXE_FWD_EN adds forwarding.
module exe_stage
    import arm_pkg::*;
#(
    parameter int DATA_W             = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
`ifdef EXE_FWD_EN
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
`endif
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] store_val,
    output logic [DATA_W-1:0] br_addr,
    output logic              br_taken,
    output logic [3:0]        status,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [3:0]        dest_out,
    output logic              stall
);

    localparam int         MUL_CYCLES = 32 / MUL_BITS_PER_CYCLE;
    localparam logic [5:0] MUL_LAST   = 6'(MUL_CYCLES - 1);

    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] val2;
    logic        is_mul;

`ifdef EXE_FWD_EN
    assign rn = fwd_mux(sel_src1, val_rn_in, mem_fwd_val, wb_fwd_val);
    assign rm = fwd_mux(sel_src2, val_rm_in, mem_fwd_val, wb_fwd_val);
`else
    assign rn = val_rn_in;
    assign rm = val_rm_in;
`endif

    exe_val2_gen u_val2 (
        .mem_en        (mem_r_en_in | mem_w_en_in),
        .imm           (imm_in),
        .shift_operand (shift_operand_in),
        .val_rm        (rm),
        .val2          (val2)
    );

    assign is_mul    = (exe_cmd_in == CMD_MUL) && wb_en_in;
    assign store_val = rm;
    assign br_addr   = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
    assign br_taken  = b_in;
    assign dest_out  = dest_in;

    // Multiplier FSM
    mul_state_t  state_q, state_d;
    logic [31:0] acc_q, mcand_q, mplier_q, acc_step;
    logic [5:0]  count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MUL_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                // Async reset must drop stall in the same cycle, even with MUL still presented.
                stall = is_mul && !rst;
                if (is_mul) state_d = MUL_BUSY;
            end
            MUL_BUSY: begin
                stall = 1'b1;
                if (count_q == MUL_LAST) state_d = MUL_DONE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) acc_step = acc_step + (mcand_q << i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else if (state_q == MUL_IDLE && is_mul) begin
            acc_q    <= '0;
            mcand_q  <= rn;
            mplier_q <= rm;
            count_q  <= '0;
        end else if (state_q == MUL_BUSY) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
            mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
            count_q  <= count_q + 6'd1;
        end
    end

    // ALU and flags. Subtracts use rn + ~val2 + cin so carry-out is NOT borrow.
    logic [31:0] add_b;
    logic        add_cin;
    logic [32:0] sum;
    logic        add_v;
    logic [31:0] res;
    logic        upd_nz, upd_cv;

    always_comb begin
        add_b   = val2;
        add_cin = 1'b0;
        case (exe_cmd_in)
            CMD_ADC: add_cin = status[1];
            CMD_SUB: begin add_b = ~val2; add_cin = 1'b1;      end
            CMD_SBC: begin add_b = ~val2; add_cin = status[1]; end
            default: ;
        endcase
    end

    assign sum   = {1'b0, rn} + {1'b0, add_b} + {32'b0, add_cin};
    assign add_v = (rn[31] == add_b[31]) && (sum[31] != rn[31]);

    always_comb begin
        res    = '0;
        upd_nz = 1'b0;
        upd_cv = 1'b0;
        case (exe_cmd_in)
            CMD_MOV: begin res = val2;       upd_nz = 1'b1; end
            CMD_MVN: begin res = ~val2;      upd_nz = 1'b1; end
            CMD_AND: begin res = rn & val2;  upd_nz = 1'b1; end
            CMD_ORR: begin res = rn | val2;  upd_nz = 1'b1; end
            CMD_EOR: begin res = rn ^ val2;  upd_nz = 1'b1; end
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                res    = sum[31:0];
                upd_nz = 1'b1;
                upd_cv = 1'b1;
            end
            CMD_MUL: begin
                if (state_q == MUL_DONE) begin
                    res    = acc_q;
                    upd_nz = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign alu_res = res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= 4'b0;
        end else if (s_in) begin
            if (upd_nz) status[3:2] <= {res[31], res == 32'b0};
            if (upd_cv) status[1:0] <= {sum[32], add_v};
        end
    end

    assign wb_en_out    = wb_en_in    && !stall;
    assign mem_r_en_out = mem_r_en_in && !stall;
    assign mem_w_en_out = mem_w_en_in && !stall;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage (define EXE_FWD_EN to cover forwarding).
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
`ifdef EXE_FWD_EN
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] mem_fwd_val, wb_fwd_val;
`endif
    logic [31:0] alu_res, store_val, br_addr;
    logic        br_taken;
    logic [3:0]  status;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [3:0]  dest_out;
    logic        stall;

    int tests = 0;
    int fails = 0;

    exe_stage dut (
        .clk              (clk),
        .rst              (rst),
        .wb_en_in         (wb_en_in),
        .mem_r_en_in      (mem_r_en_in),
        .mem_w_en_in      (mem_w_en_in),
        .b_in             (b_in),
        .s_in             (s_in),
        .exe_cmd_in       (exe_cmd_in),
        .pc_in            (pc_in),
        .val_rn_in        (val_rn_in),
        .val_rm_in        (val_rm_in),
        .imm_in           (imm_in),
        .shift_operand_in (shift_operand_in),
        .signed_imm_24_in (signed_imm_24_in),
        .dest_in          (dest_in),
`ifdef EXE_FWD_EN
        .sel_src1         (sel_src1),
        .sel_src2         (sel_src2),
        .mem_fwd_val      (mem_fwd_val),
        .wb_fwd_val       (wb_fwd_val),
`endif
        .alu_res          (alu_res),
        .store_val        (store_val),
        .br_addr          (br_addr),
        .br_taken         (br_taken),
        .status           (status),
        .wb_en_out        (wb_en_out),
        .mem_r_en_out     (mem_r_en_out),
        .mem_w_en_out     (mem_w_en_out),
        .dest_out         (dest_out),
        .stall            (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
        exe_cmd_in = 4'b0000; pc_in = 0; val_rn_in = 0; val_rm_in = 0;
        imm_in = 0; shift_operand_in = 0; signed_imm_24_in = 0; dest_in = 0;
`ifdef EXE_FWD_EN
        sel_src1 = 0; sel_src2 = 0; mem_fwd_val = 0; wb_fwd_val = 0;
`endif
    endtask

    // Wait for the next negedge and clear inputs ready for the next vector.
    task automatic nxt();
        @(negedge clk);
        clr_in();
    endtask

    // Check the combinational result, then the status after the next edge.
    task automatic alu_step(input string tag, input logic [31:0] exp_res, input logic [3:0] exp_st);
        #1;
        chk({tag, "_res"}, alu_res, exp_res);
        @(posedge clk);
        #1;
        chk({tag, "_status"}, {28'b0, status}, {28'b0, exp_st});
    endtask

    int n_stall;
    int n_bubble;
    bit done;

    initial begin
        rst = 1'b1;
        clr_in();
        #12;
        chk("reset_status", {28'b0, status}, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);

        nxt(); rst = 1'b0;
        exe_cmd_in = 4'b0010; val_rn_in = 32'h7FFFFFFF; imm_in = 1; shift_operand_in = 12'h001;
        s_in = 1; wb_en_in = 1; dest_in = 4'd7;
        #1;
        chk("add_wb_en_out", {31'b0, wb_en_out}, 32'h1);
        chk("add_dest_out", {28'b0, dest_out}, 32'h7);
        alu_step("add_s", 32'h80000000, 4'b1001);

        nxt(); exe_cmd_in = 4'b0100; val_rn_in = 5; val_rm_in = 5; s_in = 1;
        #1;
        chk("cmp_wb_en_out", {31'b0, wb_en_out}, 32'h0);
        alu_step("cmp", 32'h0, 4'b0110);

        nxt(); exe_cmd_in = 4'b0011; val_rn_in = 1; imm_in = 1; shift_operand_in = 12'h002;
        alu_step("adc_carry", 32'h4, 4'b0110);

        nxt(); exe_cmd_in = 4'b0101; val_rn_in = 3; imm_in = 1; shift_operand_in = 12'h005; s_in = 1;
        alu_step("sbc_borrow", 32'hFFFFFFFE, 4'b1000);

        nxt(); exe_cmd_in = 4'b0001; imm_in = 1; shift_operand_in = 12'h4FF;
        alu_step("mov_imm_rot", 32'hFF000000, 4'b1000);

        nxt(); exe_cmd_in = 4'b0001; val_rm_in = 32'h80000000; shift_operand_in = 12'h240;
        alu_step("mov_asr", 32'hF8000000, 4'b1000);

        nxt(); exe_cmd_in = 4'b0001; val_rm_in = 32'h000000F0; shift_operand_in = 12'h220;
        alu_step("mov_lsr", 32'h0000000F, 4'b1000);

        nxt(); exe_cmd_in = 4'b0001; val_rm_in = 32'h0000000F; shift_operand_in = 12'h260;
        alu_step("mov_ror", 32'hF0000000, 4'b1000);

        nxt(); exe_cmd_in = 4'b1001; val_rm_in = 32'h0; shift_operand_in = 12'h0;
        alu_step("mvn", 32'hFFFFFFFF, 4'b1000);

        nxt(); exe_cmd_in = 4'b1000; val_rn_in = 32'hFF00FF00; val_rm_in = 32'h0F0F0F0F; s_in = 1;
        alu_step("eor_s", 32'hF00FF00F, 4'b1000);

        nxt(); exe_cmd_in = 4'b0010; mem_r_en_in = 1; wb_en_in = 1; val_rn_in = 32'h1000;
        val_rm_in = 32'h5555; shift_operand_in = 12'hABC;
        #1;
        chk("ldr_mem_r_en_out", {31'b0, mem_r_en_out}, 32'h1);
        alu_step("ldr_addr", 32'h1ABC, 4'b1000);

        nxt(); exe_cmd_in = 4'b0010; mem_w_en_in = 1; val_rn_in = 32'h2000;
        val_rm_in = 32'hDEAD; shift_operand_in = 12'h004;
        #1;
        chk("str_store_val", store_val, 32'hDEAD);
        chk("str_mem_w_en_out", {31'b0, mem_w_en_out}, 32'h1);
        alu_step("str_addr", 32'h2004, 4'b1000);

        nxt(); exe_cmd_in = 4'b1111; val_rn_in = 32'h1234; val_rm_in = 32'h1; s_in = 1;
        alu_step("unknown_cmd", 32'h0, 4'b1000);

        nxt(); b_in = 1; pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
        #1;
        chk("br_addr", br_addr, 32'h0F8);
        chk("br_taken", {31'b0, br_taken}, 32'h1);

        // MUL with 1 bit per cycle: 33 stall cycles then result.
        nxt(); exe_cmd_in = 4'b1010; wb_en_in = 1; mem_r_en_in = 0; s_in = 1;
        val_rn_in = 32'h00010000; val_rm_in = 32'h00010001;
        #1;
        chk("mul_stall_first", {31'b0, stall}, 32'h1);
        chk("mul_bubble_first", {31'b0, wb_en_out}, 32'h0);
        n_stall = 1; n_bubble = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin val_rn_in = 32'h0; val_rm_in = 32'h0; end
            if (stall) begin
                n_stall++;
                if (wb_en_out || mem_r_en_out || mem_w_en_out) n_bubble++;
            end else begin
                done = 1;
            end
        end
        val_rn_in = 32'h00010000; val_rm_in = 32'h00010001;
        chk("mul_stall_cycles", n_stall, 33);
        chk("mul_bubbles", n_bubble, 0);
        chk("mul_res", alu_res, 32'h00010000);
        chk("mul_done_wb_en_out", {31'b0, wb_en_out}, 32'h1);
        @(posedge clk);
        #1;
        chk("mul_status", {28'b0, status}, 32'h0);
        clr_in();

        nxt(); exe_cmd_in = 4'b0100; val_rn_in = 9; imm_in = 1; shift_operand_in = 12'h009; s_in = 1;
        alu_step("cmp_pre_rst", 32'h0, 4'b0110);

        // Reset in the middle of a multiply.
        nxt(); exe_cmd_in = 4'b1010; wb_en_in = 1; val_rn_in = 3; val_rm_in = 4;
        for (int k = 0; k < 10; k++) @(posedge clk);
        #1;
        chk("mul_busy_stall", {31'b0, stall}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_mul_stall", {31'b0, stall}, 32'h0);
        chk("rst_mid_mul_status", {28'b0, status}, 32'h0);
        nxt(); rst = 1'b0;
        exe_cmd_in = 4'b0010; wb_en_in = 1; s_in = 1; val_rn_in = 32'hFFFFFFFF;
        imm_in = 1; shift_operand_in = 12'h001;
        alu_step("add_after_rst", 32'h0, 4'b0110);
        chk("add_after_rst_stall", {31'b0, stall}, 32'h0);

`ifdef EXE_FWD_EN
        nxt(); exe_cmd_in = 4'b0010; val_rn_in = 100; val_rm_in = 3;
        sel_src1 = 2'b01; mem_fwd_val = 7; wb_fwd_val = 20;
        alu_step("fwd_mem_rn", 32'd10, 4'b0110);
        nxt(); exe_cmd_in = 4'b0010; val_rn_in = 100; val_rm_in = 3;
        sel_src1 = 2'b11; mem_fwd_val = 7; wb_fwd_val = 20;
        alu_step("fwd_sel11", 32'd103, 4'b0110);
        nxt(); exe_cmd_in = 4'b0010; val_rn_in = 100; val_rm_in = 3;
        sel_src2 = 2'b10; mem_fwd_val = 7; wb_fwd_val = 20;
        #1;
        chk("fwd_wb_store_val", store_val, 32'd20);
        alu_step("fwd_wb_rm", 32'd120, 4'b0110);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
